// File: rtl/frame_pool_sampler.sv
// Down-samples a flattened frame to OUTPUT_COUNT samples by nearest tap, windowed signed max
// or windowed signed mean, stepping source indices with a remainder accumulator instead of a divider.
module frame_pool_sampler #(
   parameter int INPUT_COUNT  = 784,
   parameter int OUTPUT_COUNT = 256,
   parameter int DATA_WIDTH   = 16,
   parameter int WIN          = 4,
   parameter int WIN_LOG2     = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               abort,
   input  logic [1:0]                         mode,
   input  logic [DATA_WIDTH*INPUT_COUNT-1:0]  frame_flat,
   output logic [DATA_WIDTH*OUTPUT_COUNT-1:0] sampled_flat,
   output logic                               busy,
   output logic                               done,
   output logic                               aborted
);

   localparam int BASE   = INPUT_COUNT / OUTPUT_COUNT;
   localparam int REM    = INPUT_COUNT % OUTPUT_COUNT;
   localparam int IDX_W  = $clog2(INPUT_COUNT + BASE + WIN + 1);
   localparam int OUT_W  = $clog2(OUTPUT_COUNT + 1);
   localparam int REM_W  = $clog2(2 * OUTPUT_COUNT + 1);
   localparam int WIDX_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
   localparam int ACC_W  = DATA_WIDTH + WIN_LOG2;
   localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(INPUT_COUNT - 1);

   if (WIN != (1 << WIN_LOG2)) begin : g_win_check
      $error("frame_pool_sampler: WIN does not equal 2**WIN_LOG2");
   end
   if (OUTPUT_COUNT < 1 || OUTPUT_COUNT > INPUT_COUNT) begin : g_count_check
      $error("frame_pool_sampler: OUTPUT_COUNT out of range");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t                   state, state_next;
   logic [1:0]               mode_q;
   logic [OUT_W-1:0]         out_idx;
   logic [IDX_W-1:0]         src_base;
   logic [REM_W-1:0]         rem_accum;
   logic [WIDX_W-1:0]        win_idx;
   logic signed [ACC_W-1:0]  acc;

   logic                     win_mode, mean_mode, last_win, last_out;
   logic [IDX_W-1:0]         rd_sum, rd_idx, base_sum, base_next;
   logic signed [DATA_WIDTH-1:0] sample;
   logic signed [ACC_W-1:0]  sample_ext, acc_next, mean_val;
   logic [DATA_WIDTH-1:0]    result;
   logic [REM_W-1:0]         rem_sum, rem_next;
   logic                     carry;
   logic                     load, advance, write, finish, kill;

   assign win_mode  = (mode_q == 2'b01) || (mode_q == 2'b10);
   assign mean_mode = (mode_q == 2'b10);
   assign last_win  = !win_mode || (win_idx == WIDX_W'(WIN - 1));
   assign last_out  = (out_idx == OUT_W'(OUTPUT_COUNT - 1));
   assign busy      = (state == RUN);

   // Window reads past the end of the frame replicate the final sample.
   always_comb begin
      rd_sum = src_base;
      if (win_mode) rd_sum = src_base + IDX_W'(win_idx);
      rd_idx = (rd_sum > LAST_SRC) ? LAST_SRC : rd_sum;
   end

   assign sample     = frame_flat[rd_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sample_ext = ACC_W'(sample);

   always_comb begin
      acc_next = sample_ext;
      if (win_mode && win_idx != '0) begin
         if (mean_mode)             acc_next = acc + sample_ext;
         else if (sample_ext > acc) acc_next = sample_ext;
         else                       acc_next = acc;
      end
      mean_val = acc_next >>> WIN_LOG2;
      result   = mean_mode ? mean_val[DATA_WIDTH-1:0] : acc_next[DATA_WIDTH-1:0];
   end

   // Next base = floor((i+1)*IN/OUT), built from the integer step plus a carried remainder.
   always_comb begin
      rem_sum   = rem_accum + REM_W'(REM);
      carry     = (rem_sum >= REM_W'(OUTPUT_COUNT));
      rem_next  = carry ? rem_sum - REM_W'(OUTPUT_COUNT) : rem_sum;
      base_sum  = src_base + IDX_W'(BASE) + IDX_W'(carry);
      base_next = (base_sum > LAST_SRC) ? LAST_SRC : base_sum;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
      write      = 1'b0;
      finish     = 1'b0;
      kill       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
               kill       = 1'b1;
            end else begin
               advance = 1'b1;
               if (last_win) begin
                  write = 1'b1;
                  if (last_out) begin
                     state_next = IDLE;
                     finish     = 1'b1;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= 2'b00;
         out_idx      <= '0;
         src_base     <= '0;
         rem_accum    <= '0;
         win_idx      <= '0;
         acc          <= '0;
         sampled_flat <= '0;
         done         <= 1'b0;
         aborted      <= 1'b0;
      end else begin
         done    <= finish;
         aborted <= kill;
         if (load) begin
            mode_q    <= mode;
            out_idx   <= '0;
            src_base  <= '0;
            rem_accum <= '0;
            win_idx   <= '0;
            acc       <= '0;
         end else if (advance) begin
            acc <= acc_next;
            if (last_win) begin
               win_idx   <= '0;
               out_idx   <= out_idx + OUT_W'(1);
               src_base  <= base_next;
               rem_accum <= rem_next;
            end else begin
               win_idx <= win_idx + WIDX_W'(1);
            end
         end
         if (write) sampled_flat[out_idx*DATA_WIDTH +: DATA_WIDTH] <= result;
      end
   end

endmodule

// File: tb/tb_frame_pool_sampler.sv
// Scoreboard bench for frame_pool_sampler: a large default instance and a small clamping instance,
// checked against a direct floor(i*IN/OUT) window model.
module tb_frame_pool_sampler;

   localparam int DW   = 16;
   localparam int IC_A = 784;
   localparam int OC_A = 256;
   localparam int WN_A = 4;
   localparam int IC_B = 6;
   localparam int OC_B = 2;
   localparam int WN_B = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cycle = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   logic                 start_a = 1'b0, abort_a = 1'b0;
   logic [1:0]           mode_a = 2'b00;
   logic [DW*IC_A-1:0]   frame_a = '0;
   logic [DW*OC_A-1:0]   sampled_a;
   logic                 busy_a, done_a, aborted_a;

   logic                 start_b = 1'b0, abort_b = 1'b0;
   logic [1:0]           mode_b = 2'b00;
   logic [DW*IC_B-1:0]   frame_b = '0;
   logic [DW*OC_B-1:0]   sampled_b;
   logic                 busy_b, done_b, aborted_b;

   frame_pool_sampler #(.INPUT_COUNT(IC_A), .OUTPUT_COUNT(OC_A), .DATA_WIDTH(DW),
                        .WIN(WN_A), .WIN_LOG2(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a),
      .frame_flat(frame_a), .sampled_flat(sampled_a), .busy(busy_a),
      .done(done_a), .aborted(aborted_a));

   frame_pool_sampler #(.INPUT_COUNT(IC_B), .OUTPUT_COUNT(OC_B), .DATA_WIDTH(DW),
                        .WIN(WN_B), .WIN_LOG2(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b),
      .frame_flat(frame_b), .sampled_flat(sampled_b), .busy(busy_b),
      .done(done_b), .aborted(aborted_b));

   typedef struct {
      bit                 is_abort;
      int                 at_cycle;
      logic [DW*OC_A-1:0] vec;
   } exp_a_t;

   typedef struct {
      bit                 is_abort;
      int                 at_cycle;
      logic [DW*OC_B-1:0] vec;
   } exp_b_t;

   exp_a_t exp_a[$];
   exp_b_t exp_b[$];
   exp_a_t ea_m;
   exp_b_t eb_m;
   int fa[$], fb[$], prev_a[$], prev_b[$];
   int errors = 0;
   int checks = 0;

   // Reference: output i starts at floor(i*ic/oc); window reads clamp to the last sample.
   function automatic void ref_model(input int fr[$], input int ic, input int oc, input int win,
                                     input int md, input int nw, input int prev[$],
                                     output int res[$]);
      res = prev;
      for (int i = 0; i < nw; i++) begin
         int src, v, s, idx;
         src = (i * ic) / oc;
         if (src > ic - 1) src = ic - 1;
         v = 0;
         s = 0;
         if (md == 1 || md == 2) begin
            for (int k = 0; k < win; k++) begin
               idx = (src + k > ic - 1) ? ic - 1 : src + k;
               if (k == 0 || fr[idx] > v) v = fr[idx];
               s += fr[idx];
            end
            if (md == 2) begin
               v = s / win;
               if ((s % win) != 0 && s < 0) v = v - 1;
            end
         end else begin
            v = fr[src];
         end
         res[i] = v;
      end
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkVecA(input string name, input logic [DW*OC_A-1:0] act,
                            input logic [DW*OC_A-1:0] exv);
      checks++;
      if (act !== exv) begin
         errors++;
         for (int i = 0; i < OC_A; i++) begin
            if (act[i*DW +: DW] !== exv[i*DW +: DW]) begin
               $display("[TB] FAIL %s: entry %0d got %0d, expected %0d", name, i,
                        $signed(act[i*DW +: DW]), $signed(exv[i*DW +: DW]));
               break;
            end
         end
      end
   endtask

   task automatic checkVecB(input string name, input logic [DW*OC_B-1:0] act,
                            input logic [DW*OC_B-1:0] exv);
      checks++;
      if (act !== exv) begin
         errors++;
         for (int i = 0; i < OC_B; i++) begin
            if (act[i*DW +: DW] !== exv[i*DW +: DW]) begin
               $display("[TB] FAIL %s: entry %0d got %0d, expected %0d", name, i,
                        $signed(act[i*DW +: DW]), $signed(exv[i*DW +: DW]));
               break;
            end
         end
      end
   endtask

   // Monitors: every done/aborted pulse must match the head of its instance's queue.
   always @(posedge clk) begin
      #1;
      if (done_a || aborted_a) begin
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL a_unexpected_pulse: got done=%0b aborted=%0b, expected none",
                     done_a, aborted_a);
         end else begin
            ea_m = exp_a.pop_front();
            checkOutput("a_aborted_flag", longint'(aborted_a), longint'(ea_m.is_abort));
            checkOutput("a_done_flag", longint'(done_a), longint'(!ea_m.is_abort));
            checkOutput("a_end_cycle", longint'(cycle), longint'(ea_m.at_cycle));
            checkVecA("a_sampled", sampled_a, ea_m.vec);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (done_b || aborted_b) begin
         if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL b_unexpected_pulse: got done=%0b aborted=%0b, expected none",
                     done_b, aborted_b);
         end else begin
            eb_m = exp_b.pop_front();
            checkOutput("b_aborted_flag", longint'(aborted_b), longint'(eb_m.is_abort));
            checkOutput("b_done_flag", longint'(done_b), longint'(!eb_m.is_abort));
            checkOutput("b_end_cycle", longint'(cycle), longint'(eb_m.at_cycle));
            checkVecB("b_sampled", sampled_b, eb_m.vec);
         end
      end
   end

   task automatic loadFrameA();
      for (int k = 0; k < IC_A; k++) frame_a[k*DW +: DW] = DW'(fa[k]);
   endtask

   task automatic loadFrameB();
      for (int k = 0; k < IC_B; k++) frame_b[k*DW +: DW] = DW'(fb[k]);
   endtask

   task automatic randFrameA();
      fa.delete();
      for (int k = 0; k < IC_A; k++) fa.push_back(int'($signed(DW'($urandom))));
      loadFrameA();
   endtask

   task automatic randFrameB();
      fb.delete();
      for (int k = 0; k < IC_B; k++) fb.push_back(int'($signed(DW'($urandom))));
      loadFrameB();
   endtask

   // Called on a negedge; start is sampled on the next posedge.
   task automatic applyStimulusA(input int md, input int n_abort, input int stray,
                                 input bit with_abort);
      exp_a_t e;
      int res[$];
      int c, t, nw;
      c  = (md == 1 || md == 2) ? WN_A : 1;
      t  = cycle + 1;
      nw = (n_abort >= 0) ? n_abort : OC_A;
      ref_model(fa, IC_A, OC_A, WN_A, md, nw, prev_a, res);
      prev_a     = res;
      e.is_abort = (n_abort >= 0);
      e.at_cycle = e.is_abort ? t + n_abort * c + 1 : t + OC_A * c;
      e.vec      = '0;
      for (int i = 0; i < OC_A; i++) e.vec[i*DW +: DW] = DW'(res[i]);
      exp_a.push_back(e);
      mode_a  = 2'(md);
      start_a = 1'b1;
      abort_a = with_abort;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      mode_a  = 2'($urandom_range(0, 3));
      checkOutput("a_busy_after_start", longint'(busy_a), 1);
      if (stray > 0) begin
         repeat (stray) @(negedge clk);
         start_a = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
      end
      if (e.is_abort) begin
         while (cycle < e.at_cycle - 1) @(negedge clk);
         abort_a = 1'b1;
         @(negedge clk);
         abort_a = 1'b0;
      end
   endtask

   task automatic applyStimulusB(input int md, input bit with_abort);
      exp_b_t e;
      int res[$];
      int c, t;
      c = (md == 1 || md == 2) ? WN_B : 1;
      t = cycle + 1;
      ref_model(fb, IC_B, OC_B, WN_B, md, OC_B, prev_b, res);
      prev_b     = res;
      e.is_abort = 1'b0;
      e.at_cycle = t + OC_B * c;
      e.vec      = '0;
      for (int i = 0; i < OC_B; i++) e.vec[i*DW +: DW] = DW'(res[i]);
      exp_b.push_back(e);
      mode_b  = 2'(md);
      start_b = 1'b1;
      abort_b = with_abort;
      @(negedge clk);
      start_b = 1'b0;
      abort_b = 1'b0;
      mode_b  = 2'($urandom_range(0, 3));
      checkOutput("b_busy_after_start", longint'(busy_b), 1);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d/%0d pending after %0d cycles, expected 0",
                  exp_a.size(), exp_b.size(), budget);
         exp_a.delete();
         exp_b.delete();
      end
      @(negedge clk);
   endtask

   task automatic applyReset();
      exp_a.delete();
      exp_b.delete();
      prev_a.delete();
      prev_b.delete();
      for (int i = 0; i < OC_A; i++) prev_a.push_back(0);
      for (int i = 0; i < OC_B; i++) prev_b.push_back(0);
      start_a = 1'b0;
      abort_a = 1'b0;
      start_b = 1'b0;
      abort_b = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("a_reset_busy", longint'(busy_a), 0);
      checkOutput("a_reset_done", longint'(done_a), 0);
      checkOutput("a_reset_aborted", longint'(aborted_a), 0);
      checkOutput("a_reset_sampled_nonzero", longint'(sampled_a !== '0), 0);
      checkOutput("b_reset_busy", longint'(busy_b), 0);
      checkOutput("b_reset_done", longint'(done_b), 0);
      checkOutput("b_reset_aborted", longint'(aborted_b), 0);
      checkOutput("b_reset_sampled_nonzero", longint'(sampled_b !== '0), 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      @(negedge clk);
      @(negedge clk);
      applyReset();

      // Ramp frame in tap mode gives the index map directly.
      fa.delete();
      for (int k = 0; k < IC_A; k++) fa.push_back(k);
      loadFrameA();
      applyStimulusA(0, -1, 0, 1'b0);
      waitDrain(400);
      checkOutput("a_ramp_entry0", longint'(sampled_a[0*DW +: DW]), 0);
      checkOutput("a_ramp_entry1", longint'(sampled_a[1*DW +: DW]), 3);
      checkOutput("a_ramp_entry85", longint'(sampled_a[85*DW +: DW]), 260);
      checkOutput("a_ramp_entry255", longint'(sampled_a[255*DW +: DW]), 780);

      for (int md = 1; md <= 3; md++) begin
         randFrameA();
         applyStimulusA(md, -1, 0, 1'b0);
         waitDrain(1500);
      end

      // Abort after three tap outputs, then a run with a stray start while busy.
      randFrameA();
      applyStimulusA(0, 3, 0, 1'b0);
      waitDrain(50);
      randFrameA();
      applyStimulusA(0, -1, 10, 1'b0);
      waitDrain(400);

      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("a_idle_abort_busy", longint'(busy_a), 0);

      // Small instance: clamped mean window, start beating abort, back-to-back starts.
      fb.delete();
      for (int k = 0; k < IC_B; k++) fb.push_back(k);
      loadFrameB();
      applyStimulusB(2, 1'b0);
      waitDrain(50);
      checkOutput("b_ramp_mean0", longint'($signed(sampled_b[0*DW +: DW])), 1);
      checkOutput("b_ramp_mean1", longint'($signed(sampled_b[1*DW +: DW])), 4);

      randFrameB();
      applyStimulusB(1, 1'b1);
      waitDrain(50);

      randFrameB();
      applyStimulusB(1, 1'b0);
      n = 0;
      while (!done_b && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b_done_seen", longint'(done_b), 1);
      applyStimulusB(2, 1'b0);
      waitDrain(50);

      for (int r = 0; r < 8; r++) begin
         randFrameB();
         applyStimulusB($urandom_range(0, 3), 1'b0);
         waitDrain(50);
      end

      // Reset in the middle of a max-pool run, then a clean rerun.
      randFrameA();
      applyStimulusA(1, -1, 0, 1'b0);
      repeat (40) @(negedge clk);
      applyReset();
      repeat (5) @(negedge clk);
      checkOutput("a_post_reset_busy", longint'(busy_a), 0);
      applyStimulusA(1, -1, 0, 1'b0);
      waitDrain(1500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
